io_test_sequencer: RTL and testbench
====================================

Name: io_test_sequencer

Overview:
Synthesizable, parametrised on-chip self-test harness for the single-cycle computer. It derives the CPU clock from the fast memory clock, stretches the CPU reset, and drives N_IN programmable input-port values. It then watches N_OUT output ports until they hold the expected values, reporting pass/fail and elapsed cycles. It sits between board I/O (switches/LEDs) and sc_computer_module, replacing the fixed simulation stimulus with a configurable, self-checking sequencer usable on hardware and in simulation.

Parameters:
N_IN, 2, number of CPU input ports driven
N_OUT, 3, number of CPU output ports checked
DATA_W, 32, width of each input port and of cfg_wdata
OUT_W, 5, width of each output port
RST_CYCLES, 5, clock_50M cycles cpu_resetn is held low in RESET state (min 1)
TIMEOUT, 62500, clock_50M cycles allowed in RUN before FAIL (min 1)
MATCH_HOLD, 4, consecutive matching samples required for PASS (min 1)
(derived localparam ADDR_W = clog2(N_IN+N_OUT), CNT_W = clog2(TIMEOUT+1))

Ports:
clock_50M  in  1  fast clock, also the memory clock
resetn  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  ADDR_W  0..N_IN-1 = input port value; N_IN..N_IN+N_OUT-1 = expected output value
cfg_wdata  in  DATA_W  config data (expected values use low OUT_W bits)
start  in  1  single-cycle start pulse
out_port_i  in  N_OUT*OUT_W  CPU output ports, channel k at [k*OUT_W +: OUT_W]
cpu_clk  out  1  CPU clock = clock_50M/2
cpu_resetn  out  1  CPU reset, active low
in_port_o  out  N_IN*DATA_W  CPU input ports, channel k at [k*DATA_W +: DATA_W]
busy  out  1  high in RESET or RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS only
cycles  out  CNT_W  clock_50M cycles spent in RUN, frozen in PASS/FAIL

Behaviour:
- Reset values: cpu_clk=1, cpu_resetn=0, in_port_o=0, expected regs=0, busy=done=pass=0, cycles=0, state=IDLE, match_cnt=0.
- cpu_clk toggles on every clock_50M rising edge after reset release, free-running and independent of state.
- Config writes: accepted in IDLE, PASS and FAIL; ignored while busy. Out-of-range cfg_addr is ignored. Writes take effect the next cycle. in_port_o is driven continuously from the registers.
- out_port_i is registered once (sample stage). Comparisons use the registered value, so there is 1 cycle of latency.
- FSM:
  - IDLE: cpu_resetn=0. On start go to RESET, load rst_cnt=RST_CYCLES-1.
  - RESET: cpu_resetn=0. Decrement rst_cnt. At 0 go to RUN, clear cycles and match_cnt.
  - RUN: cpu_resetn=1; cycles increments each cycle.
    - All channels of the sample equal expected: match_cnt++ (saturating). Otherwise match_cnt=0.
    - match_cnt reaching MATCH_HOLD: go to PASS.
    - cycles reaching TIMEOUT: go to FAIL.
    - Both in the same cycle: PASS wins.
  - PASS / FAIL: cpu_resetn stays 1 so the CPU stays observable. cycles frozen. A start pulse restarts at RESET; the config is retained.
- start is ignored in RESET and RUN.
- resetn asserted mid-run: everything returns to reset values asynchronously, including the config registers.
- cycles saturates at TIMEOUT and never wraps.

Decomposition:
- Shared package io_test_pkg: state encoding constants (IDLE, RESET, RUN, PASS, FAIL) and the ADDR_W/CNT_W width helper function.
- One natural sub-module, io_port_bank: a parametrised register file holding the N_IN input and N_OUT expected values, with write decode and flattened outputs.
- FSM, counters and comparator stay in the top module.

Test Plan:
- Reset and clocking: resetn low for 5 cycles, then high -> all outputs at reset values during reset; cpu_clk toggles each clock_50M edge with period = 2 clock_50M cycles; cpu_resetn=0 in IDLE.
- Config and stimulus: write addr0=15, addr1=7 -> in_port_o channel0=15, channel1=7 one cycle later. Write during RUN is ignored: value unchanged.
- Pass path: expected out0=22, out1=15, out2=7; start; model drives the matching outputs from RUN cycle 10 onward -> cpu_resetn low for exactly 5 cycles; PASS with pass=1, done=1; cycles=10+1+MATCH_HOLD-1 (sample latency).
- Glitch resets the match run: matching for 3 cycles, one mismatched cycle, then matching -> no PASS until 4 consecutive matches after the glitch.
- Timeout: TIMEOUT=20, outputs never match -> FAIL at cycles=20, pass=0, done=1. Match completing on the same cycle as the timeout -> PASS.
- Restart and mid-run reset: start from FAIL -> RESET again with config retained. resetn pulsed low mid-RUN -> immediate return to IDLE, in_port_o=0.

Source files
------------

// File: rtl/io_test_pkg.sv
// Shared state encoding and width helper for the I/O test sequencer.
package io_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  // Bits needed to index/count n distinct values, never less than one.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_port_bank.sv
// Register file holding the CPU input-port values and the expected output values.
module io_port_bank #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 3,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 5,
  parameter int ADDR_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [N_IN*DATA_W-1:0]  in_port_o,
  output logic [N_OUT*OUT_W-1:0]  exp_o
);

  genvar gi;

  for (gi = 0; gi < N_IN; gi++) begin : g_in
    logic [DATA_W-1:0] val_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        val_q <= '0;
      end else if (we_i && (addr_i == ADDR_W'(gi))) begin
        val_q <= wdata_i;
      end
    end
    assign in_port_o[gi*DATA_W +: DATA_W] = val_q;
  end

  // Expected values sit above the input ports; addresses past the end never decode.
  for (gi = 0; gi < N_OUT; gi++) begin : g_exp
    logic [OUT_W-1:0] val_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        val_q <= '0;
      end else if (we_i && (addr_i == ADDR_W'(N_IN + gi))) begin
        val_q <= wdata_i[OUT_W-1:0];
      end
    end
    assign exp_o[gi*OUT_W +: OUT_W] = val_q;
  end

endmodule

// File: rtl/io_test_sequencer.sv
// Self-test harness: derives the CPU clock, stretches CPU reset, drives input
// ports and waits for the output ports to settle on their expected values.
module io_test_sequencer
  import io_test_pkg::*;
#(
  parameter int  N_IN       = 2,
  parameter int  N_OUT      = 3,
  parameter int  DATA_W     = 32,
  parameter int  OUT_W      = 5,
  parameter int  RST_CYCLES = 5,
  parameter int  TIMEOUT    = 62500,
  parameter int  MATCH_HOLD = 4,
  localparam int ADDR_W     = width_for(N_IN + N_OUT),
  localparam int CNT_W      = width_for(TIMEOUT + 1)
) (
  input  logic                    clock_50M,
  input  logic                    resetn,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [DATA_W-1:0]       cfg_wdata,
  input  logic                    start,
  input  logic [N_OUT*OUT_W-1:0]  out_port_i,
  output logic                    cpu_clk,
  output logic                    cpu_resetn,
  output logic [N_IN*DATA_W-1:0]  in_port_o,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        cycles
);

  localparam int RST_W   = width_for(RST_CYCLES);
  localparam int MATCH_W = width_for(MATCH_HOLD + 1);

  state_e                 state_q, state_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;
  logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
  logic                   cpu_clk_q;
  logic [N_OUT*OUT_W-1:0] sample_q;
  logic [N_OUT*OUT_W-1:0] exp_flat;
  logic [N_OUT-1:0]       ch_eq;
  logic                   all_match;

  io_port_bank #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk_i     (clock_50M),
    .rst_ni    (resetn),
    .we_i      (cfg_we && !busy),
    .addr_i    (cfg_addr),
    .wdata_i   (cfg_wdata),
    .in_port_o (in_port_o),
    .exp_o     (exp_flat)
  );

  genvar gi;
  for (gi = 0; gi < N_OUT; gi++) begin : g_cmp
    assign ch_eq[gi] = (sample_q[gi*OUT_W +: OUT_W] == exp_flat[gi*OUT_W +: OUT_W]);
  end
  assign all_match = &ch_eq;

  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      cycles_q    <= '0;
      match_cnt_q <= '0;
      cpu_clk_q   <= 1'b1;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      match_cnt_q <= match_cnt_d;
      cpu_clk_q   <= ~cpu_clk_q;
      sample_q    <= out_port_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycles_d    = cycles_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          state_d   = RESET;
          rst_cnt_d = RST_W'(RST_CYCLES - 1);
        end
      end
      RESET: begin
        if (rst_cnt_q == '0) begin
          state_d     = RUN;
          cycles_d    = '0;
          match_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      RUN: begin
        cycles_d = (cycles_q < CNT_W'(TIMEOUT)) ? cycles_q + 1'b1 : cycles_q;
        if (all_match) begin
          match_cnt_d = (match_cnt_q < MATCH_W'(MATCH_HOLD)) ? match_cnt_q + 1'b1 : match_cnt_q;
        end else begin
          match_cnt_d = '0;
        end
        // A match completing on the timeout cycle still counts as a pass.
        if (match_cnt_d == MATCH_W'(MATCH_HOLD)) begin
          state_d = PASS;
        end else if (cycles_d == CNT_W'(TIMEOUT)) begin
          state_d = FAIL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RESET) || (state_q == RUN);
  assign done       = (state_q == PASS) || (state_q == FAIL);
  assign pass       = (state_q == PASS);
  assign cpu_resetn = (state_q == RUN) || done;
  assign cpu_clk    = cpu_clk_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_io_test_sequencer.sv
// Randomised and directed bench for io_test_sequencer against a behavioural model.
module tb_io_test_sequencer;

  localparam int N_IN = 2, N_OUT = 3, DATA_W = 32, OUT_W = 5;
  localparam int RST_CYCLES = 5, TIMEOUT = 20, MATCH_HOLD = 4;
  localparam int ADDR_W = 3, CNT_W = 5;
  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_PASS = 3, P_FAIL = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cfg_we = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wdata = '0;
  logic [N_OUT*OUT_W-1:0] out_port = '0;
  logic cpu_clk, cpu_resetn, busy, done, pass;
  logic [N_IN*DATA_W-1:0] in_port;
  logic [CNT_W-1:0] cycles;

  int checks = 0;
  int failures = 0;

  io_test_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .OUT_W(OUT_W),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .MATCH_HOLD(MATCH_HOLD)
  ) dut (
    .clock_50M(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .out_port_i(out_port),
    .cpu_clk(cpu_clk), .cpu_resetn(cpu_resetn), .in_port_o(in_port),
    .busy(busy), .done(done), .pass(pass), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase, remaining reset cycles, run length, match streak.
  int m_phase = P_IDLE;
  int m_rst_left = 0;
  int m_cycles = 0;
  int m_streak = 0;
  bit m_clk = 1'b1;
  logic [DATA_W-1:0] m_in [N_IN] = '{default: '0};
  int m_exp [N_OUT] = '{default: 0};
  int m_samp [N_OUT] = '{default: 0};

  task automatic model_reset();
    m_phase = P_IDLE; m_rst_left = 0; m_cycles = 0; m_streak = 0; m_clk = 1'b1;
    for (int k = 0; k < N_IN; k++) m_in[k] = '0;
    for (int k = 0; k < N_OUT; k++) begin m_exp[k] = 0; m_samp[k] = 0; end
  endtask

  task automatic model_step();
    bit all_eq;
    int a;
    all_eq = 1'b1;
    for (int k = 0; k < N_OUT; k++) if (m_samp[k] != m_exp[k]) all_eq = 1'b0;
    m_clk = !m_clk;
    a = int'(cfg_addr);
    if (cfg_we && m_phase != P_RST && m_phase != P_RUN) begin
      if (a < N_IN) m_in[a] = cfg_wdata;
      else if (a < N_IN + N_OUT) m_exp[a - N_IN] = int'(cfg_wdata % (1 << OUT_W));
    end
    case (m_phase)
      P_RST: begin
        m_rst_left = m_rst_left - 1;
        if (m_rst_left == 0) begin m_phase = P_RUN; m_cycles = 0; m_streak = 0; end
      end
      P_RUN: begin
        m_cycles = (m_cycles + 1 > TIMEOUT) ? TIMEOUT : m_cycles + 1;
        m_streak = all_eq ? ((m_streak + 1 > MATCH_HOLD) ? MATCH_HOLD : m_streak + 1) : 0;
        if (m_streak == MATCH_HOLD) m_phase = P_PASS;
        else if (m_cycles == TIMEOUT) m_phase = P_FAIL;
      end
      default: if (start) begin m_phase = P_RST; m_rst_left = RST_CYCLES; end
    endcase
    for (int k = 0; k < N_OUT; k++) m_samp[k] = int'(out_port[k*OUT_W +: OUT_W]);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cpu_clk", 64'(cpu_clk), 64'(m_clk));
      chk("cpu_resetn", 64'(cpu_resetn), 64'(m_phase == P_RUN || m_phase == P_PASS || m_phase == P_FAIL));
      chk("busy", 64'(busy), 64'(m_phase == P_RST || m_phase == P_RUN));
      chk("done", 64'(done), 64'(m_phase == P_PASS || m_phase == P_FAIL));
      chk("pass", 64'(pass), 64'(m_phase == P_PASS));
      chk("cycles", 64'(cycles), 64'(m_cycles));
      for (int k = 0; k < N_IN; k++) chk("in_port", 64'(in_port[k*DATA_W +: DATA_W]), 64'(m_in[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(addr); cfg_wdata = DATA_W'(data);
    step();
    cfg_we = 1'b0;
  endtask

  function automatic logic [N_OUT*OUT_W-1:0] pack_exp();
    logic [N_OUT*OUT_W-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k*OUT_W +: OUT_W] = OUT_W'(m_exp[k]);
    return v;
  endfunction

  // Output pattern per run cycle; the value set now is sampled when cycles == m_cycles.
  function automatic logic [N_OUT*OUT_W-1:0] pick_out(input int mode);
    bit m;
    case (mode)
      1: m = (m_cycles >= 9);
      2: m = (m_cycles >= 1 && m_cycles <= 3) || (m_cycles >= 5);
      3: m = (m_cycles >= 15 && m_cycles <= 18);
      default: m = 1'b0;
    endcase
    if (m_phase != P_RUN) m = 1'b0;
    return m ? pack_exp() : '0;
  endfunction

  int run_no = 0;

  task automatic run_test(input string name, input int mode, input int exp_pass, input int exp_cycles);
    int rst_lo;
    int n;
    rst_lo = 0; n = 0;
    start = 1'b1; step(); start = 1'b0;
    while (!done && n < 200) begin
      if (busy && !cpu_resetn) rst_lo++;
      cfg_we = (mode == 1 && m_phase == P_RUN && m_cycles == 3);
      cfg_addr = '0; cfg_wdata = 99;
      out_port = pick_out(mode);
      step();
      cfg_we = 1'b0;
      n++;
    end
    run_no++;
    $display("run %0d %s: done=%0d pass=%0d cycles=%0d reset_cycles=%0d", run_no, name, done, pass, cycles, rst_lo);
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_reset_len"}, 64'(rst_lo), 64'(RST_CYCLES));
    chk({name, "_pass"}, 64'(pass), 64'(exp_pass));
    chk({name, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    out_port = '0;
  endtask

  initial begin
    bit a;
    int n;
    repeat (5) step();
    chk("rst_cpu_clk", 64'(cpu_clk), 64'd1);
    chk("rst_cpu_resetn", 64'(cpu_resetn), 64'd0);
    chk("rst_in_port", 64'(in_port), 64'd0);
    chk("rst_busy_done_pass", 64'({busy, done, pass}), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    resetn = 1'b1;
    step();
    chk("clk_first_toggle", 64'(cpu_clk), 64'd0);
    a = cpu_clk;
    step(); chk("clk_half", 64'(cpu_clk), 64'(!a));
    step(); chk("clk_period", 64'(cpu_clk), 64'(a));
    chk("idle_cpu_resetn", 64'(cpu_resetn), 64'd0);

    cfg_write(0, 15);
    chk("cfg_ch0", 64'(in_port[0 +: DATA_W]), 64'd15);
    cfg_write(1, 7);
    chk("cfg_ch1", 64'(in_port[DATA_W +: DATA_W]), 64'd7);
    cfg_write(2, 22); cfg_write(3, 15); cfg_write(4, 7);
    cfg_write(6, 32'hDEAD);
    chk("oob_write", 64'(in_port), {32'd7, 32'd15});

    run_test("pass_path", 1, 1, 14);
    chk("run_write_ignored", 64'(in_port[0 +: DATA_W]), 64'd15);
    run_test("timeout", 0, 0, 20);
    run_test("glitch", 2, 1, 10);
    run_test("same_cycle", 3, 1, 20);

    start = 1'b1; step(); start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_cfg_kept", 64'(in_port[0 +: DATA_W]), 64'd15);
    n = 0;
    while (!(busy && cpu_resetn) && n < 50) begin step(); n++; end
    chk("reach_run", 64'(busy && cpu_resetn), 64'd1);
    repeat (3) step();
    resetn = 1'b0;
    #1;
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_cpu_resetn", 64'(cpu_resetn), 64'd0);
    chk("midrun_in_port", 64'(in_port), 64'd0);
    chk("midrun_cycles", 64'(cycles), 64'd0);
    step(); step();
    resetn = 1'b1;
    step();

    for (int i = 0; i < 1500; i++) begin
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = ADDR_W'($urandom_range(0, 7));
      cfg_wdata = (cfg_addr >= 2) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
      start = ($urandom_range(0, 15) == 0);
      out_port = ($urandom_range(0, 3) != 0) ? pack_exp() : (N_OUT*OUT_W)'($urandom);
      resetn = ($urandom_range(0, 399) != 0);
      step();
    end
    cfg_we = 1'b0; start = 1'b0; resetn = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
